// File: rtl/tbb1143_bus_pkg.sv
// Shared types for the TBB1143 register-bus write sequencer.
// Covers FSM and sub-phase encodings, the queued write request and the nibble width.
package tbb1143_bus_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DLO  = 2'd2,
        DHI  = 2'd3
    } fsm_t;

    typedef enum logic [1:0] {
        SETUP  = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } subph_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wreq_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tbb1143_wr_fifo.sv
// Small power-of-two FIFO of pending register writes.
// Pointers wrap naturally; the count carries one extra bit so that full and empty stay distinct.
module tbb1143_wr_fifo
    import tbb1143_bus_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic          pop,
    input  wreq_t         din,
    output wreq_t         dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wreq_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is data only and carries no reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/tbb1143_write_sequencer.sv
// Round-robin arbitration of two register-write requesters into a FIFO.
// Each entry is serialised as address, low and high data nibbles onto the TBB1143 4-bit bus.
module tbb1143_write_sequencer
    import tbb1143_bus_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_VALID,
    input  logic [3:0]       A_ADDR,
    input  logic [7:0]       A_DATA,
    output logic             A_READY,
    input  logic             B_VALID,
    input  logic [3:0]       B_ADDR,
    input  logic [7:0]       B_DATA,
    output logic             B_READY,
    output logic [NIB_W-1:0] BUS_D,
    output logic             BUS_A0,
    output logic             BUS_WR,
    output logic             BUSY
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXPH = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int PW    = (MAXPH > 1) ? $clog2(MAXPH) : 1;

    fsm_t             state;
    fsm_t             state_n;
    subph_t           subph;
    subph_t           subph_n;
    logic [PW-1:0]    ph_cnt;
    logic [PW-1:0]    ph_cnt_n;
    logic             rr_b;
    logic             a_grant;
    logic             b_grant;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    wreq_t            push_req;
    wreq_t            head_req;
    wreq_t            shadow_p0;
    wreq_t            shadow_n;
    logic [NIB_W-1:0] bus_d_n;
    logic             bus_a0_n;
    logic             bus_wr_n;

    function automatic logic [PW-1:0] ph_last(input subph_t s);
        case (s)
            SETUP:   return PW'(SETUP_CYC - 1);
            STROBE:  return PW'(STROBE_CYC - 1);
            default: return PW'(HOLD_CYC - 1);
        endcase
    endfunction

    // Space is judged on the registered count, so a same-cycle pop never makes room.
    assign a_grant   = RST && !fifo_full && A_VALID && (!B_VALID || !rr_b);
    assign b_grant   = RST && !fifo_full && B_VALID && (!A_VALID || rr_b);
    assign A_READY   = a_grant;
    assign B_READY   = b_grant;
    assign fifo_push = a_grant || b_grant;
    assign BUSY      = (fifo_count != '0) || (state != IDLE);

    always_comb begin
        push_req = '0;
        if (a_grant) begin
            push_req.addr = A_ADDR;
            push_req.data = A_DATA;
        end else begin
            push_req.addr = B_ADDR;
            push_req.data = B_DATA;
        end
    end

    tbb1143_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_req),
        .dout  (head_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next state: nibble phase walks SETUP -> STROBE -> HOLD, then the next nibble.
    always_comb begin
        state_n  = state;
        subph_n  = subph;
        ph_cnt_n = ph_cnt;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = ADDR;
                    subph_n  = SETUP;
                    ph_cnt_n = '0;
                end
            end
            default: begin
                if (ph_cnt == ph_last(subph)) begin
                    ph_cnt_n = '0;
                    case (subph)
                        SETUP:  subph_n = STROBE;
                        STROBE: subph_n = HOLD;
                        default: begin
                            subph_n = SETUP;
                            case (state)
                                ADDR: state_n = DLO;
                                DLO:  state_n = DHI;
                                default: begin
                                    // Chain straight into the next write when one is waiting.
                                    if (!fifo_empty) begin
                                        fifo_pop = 1'b1;
                                        state_n  = ADDR;
                                    end else begin
                                        state_n = IDLE;
                                    end
                                end
                            endcase
                        end
                    endcase
                end else begin
                    ph_cnt_n = ph_cnt + PW'(1);
                end
            end
        endcase
    end

    // Bus pins are registered from the next state so WR can never glitch.
    always_comb begin
        shadow_n = fifo_pop ? head_req : shadow_p0;
        bus_d_n  = BUS_D;
        bus_a0_n = BUS_A0;
        bus_wr_n = 1'b0;
        case (state_n)
            ADDR: begin
                bus_a0_n = 1'b1;
                bus_d_n  = shadow_n.addr;
            end
            DLO: begin
                bus_a0_n = 1'b0;
                bus_d_n  = shadow_n.data[3:0];
            end
            DHI: begin
                bus_a0_n = 1'b0;
                bus_d_n  = shadow_n.data[7:4];
            end
            default: begin
                bus_a0_n = BUS_A0;
                bus_d_n  = BUS_D;
            end
        endcase
        if (state_n != IDLE) begin
            bus_wr_n = (subph_n == STROBE);
        end
    end

    always_ff @(posedge CLK) begin
        shadow_p0 <= shadow_n;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            subph  <= SETUP;
            ph_cnt <= '0;
            rr_b   <= 1'b0;
            BUS_D  <= '0;
            BUS_A0 <= 1'b0;
            BUS_WR <= 1'b0;
        end else begin
            state  <= state_n;
            subph  <= subph_n;
            ph_cnt <= ph_cnt_n;
            if (fifo_push) begin
                rr_b <= a_grant;
            end
            BUS_D  <= bus_d_n;
            BUS_A0 <= bus_a0_n;
            BUS_WR <= bus_wr_n;
        end
    end

endmodule

// File: tb/tb_tbb1143_write_sequencer.sv
// Scoreboard bench for the TBB1143 write sequencer: default timing instance plus a
// SETUP=2/STROBE=1/HOLD=3 instance checked against a cycle table.
module tb_tbb1143_write_sequencer;

    localparam int P1      = 4;
    localparam int STROBE1 = 2;

    typedef struct packed {
        logic       a0;
        logic [3:0] d;
    } nib_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } req_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       A_VALID, B_VALID;
    logic [3:0] A_ADDR, B_ADDR;
    logic [7:0] A_DATA, B_DATA;
    logic       A_READY, B_READY;
    logic [3:0] BUS_D;
    logic       BUS_A0, BUS_WR, BUSY;

    logic       RST2;
    logic       A2_VALID, B2_VALID;
    logic [3:0] A2_ADDR, B2_ADDR;
    logic [7:0] A2_DATA, B2_DATA;
    logic       A2_READY, B2_READY;
    logic [3:0] BUS2_D;
    logic       BUS2_A0, BUS2_WR, BUSY2;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   stall = 0;
    bit   burst_first = 1'b1;
    nib_t exq[$];
    req_t aq[$];
    req_t bq[$];
    int   gq[$];
    int   rise_log[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    tbb1143_write_sequencer #(
        .DEPTH(4), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)
    ) u_dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .BUS_D(BUS_D), .BUS_A0(BUS_A0), .BUS_WR(BUS_WR), .BUSY(BUSY)
    );

    tbb1143_write_sequencer #(
        .DEPTH(4), .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)
    ) u_dut2 (
        .CLK(CLK), .RST(RST2),
        .A_VALID(A2_VALID), .A_ADDR(A2_ADDR), .A_DATA(A2_DATA), .A_READY(A2_READY),
        .B_VALID(B2_VALID), .B_ADDR(B2_ADDR), .B_DATA(B2_DATA), .B_READY(B2_READY),
        .BUS_D(BUS2_D), .BUS_A0(BUS2_A0), .BUS_WR(BUS2_WR), .BUSY(BUSY2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_write(input logic [3:0] a, input logic [7:0] d);
        exq.push_back(nib_t'{1'b1, a});
        exq.push_back(nib_t'{1'b0, d[3:0]});
        exq.push_back(nib_t'{1'b0, d[7:4]});
    endtask

    // Requester driver: presents queue heads, logs and checks grant order.
    initial begin
        bit fa, fb;
        A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
        B_VALID = 1'b0; B_ADDR = '0; B_DATA = '0;
        forever begin
            @(negedge CLK);
            fa = A_VALID && A_READY;
            fb = B_VALID && B_READY;
            @(posedge CLK);
            #1;
            if (fa || fb) begin
                chk("single_grant", int'(fa && fb), 0);
                if (gq.size() == 0) chk("grant_unexpected", 1, 0);
                else chk("grant_order", fa ? 0 : 1, gq.pop_front());
                last_acc = cyc;
            end
            if (fa) void'(aq.pop_front());
            if (fb) void'(bq.pop_front());
            A_VALID = (aq.size() != 0);
            if (A_VALID) begin A_ADDR = aq[0].addr; A_DATA = aq[0].data; end
            B_VALID = (bq.size() != 0);
            if (B_VALID) begin B_ADDR = bq[0].addr; B_DATA = bq[0].data; end
        end
    end

    // Bus monitor: pops one expected nibble per WR rising edge.
    initial begin
        bit   prev_wr;
        int   hi_cnt;
        int   last_rise;
        nib_t cur, e;
        prev_wr = 1'b0; hi_cnt = 0; last_rise = 0; cur = '0;
        forever begin
            @(negedge CLK);
            if (RST && A_VALID && !A_READY) stall++;
            if (!RST) begin
                prev_wr = 1'b0;
            end else begin
                if (BUS_WR && !prev_wr) begin
                    rise_log.push_back(cyc);
                    hi_cnt = 1;
                    cur = nib_t'{BUS_A0, BUS_D};
                    if (exq.size() == 0) begin
                        chk("nib_unexpected", 1, 0);
                    end else begin
                        e = exq.pop_front();
                        chk("nib_a0", BUS_A0, e.a0);
                        chk("nib_d", BUS_D, e.d);
                    end
                    if (!burst_first) chk("pulse_gap", cyc - last_rise, P1);
                    burst_first = 1'b0;
                    last_rise = cyc;
                end else if (BUS_WR) begin
                    hi_cnt++;
                    chk("nib_stable", {BUS_A0, BUS_D}, cur);
                end else if (prev_wr) begin
                    chk("strobe_width", hi_cnt, STROBE1);
                end
                prev_wr = BUS_WR;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            #1;
            if (!BUSY && aq.size() == 0 && bq.size() == 0 && exq.size() == 0) done = 1'b1;
        end
        chk({name, "_idle_timeout"}, int'(done), 1);
    endtask

    task automatic do_reset(input string name);
        @(posedge CLK);
        #1 RST = 1'b0;
        #2;
        chk({name, "_bus_d"}, BUS_D, 0);
        chk({name, "_bus_a0"}, BUS_A0, 0);
        chk({name, "_bus_wr"}, BUS_WR, 0);
        chk({name, "_busy"}, BUSY, 0);
        exq.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    initial begin #100000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

    initial begin
        int base, acc1, nibv;
        bit done;
        logic [3:0] ed;
        RST = 1'b0;
        RST2 = 1'b0;
        A2_VALID = 1'b0; A2_ADDR = '0; A2_DATA = '0;
        B2_VALID = 1'b0; B2_ADDR = '0; B2_DATA = '0;

        // T1: single write requested while reset is held; must wait for release.
        aq.push_back(req_t'{4'h3, 8'hA5}); gq.push_back(0); exp_write(4'h3, 8'hA5);
        repeat (3) @(negedge CLK);
        chk("rst_bus_d", BUS_D, 0);
        chk("rst_bus_a0", BUS_A0, 0);
        chk("rst_bus_wr", BUS_WR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_a_valid_seen", A_VALID, 1);
        chk("rst_a_ready", A_READY, 0);
        chk("rst_b_ready", B_READY, 0);
        base = rise_log.size();
        @(posedge CLK); #1 RST = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin @(negedge CLK); if (aq.size() == 0) done = 1'b1; end
        chk("t1_accept_timeout", int'(done), 1);
        acc1 = last_acc;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin @(negedge CLK); #1; if (!BUSY) done = 1'b1; end
        chk("t1_busy_timeout", int'(done), 1);
        chk("t1_busy_cycles", cyc - acc1, 13);
        chk("t1_rises", rise_log.size() - base, 3);
        if (rise_log.size() > base) chk("t1_first_rise", rise_log[base] - acc1, 2);
        chk("t1_idle_d", BUS_D, 4'hA);
        chk("t1_idle_a0", BUS_A0, 0);
        chk("t1_idle_wr", BUS_WR, 0);

        // T2: simultaneous A/B after reset; A first, B next, pulses contiguous.
        do_reset("t2_rst");
        burst_first = 1'b1; base = rise_log.size();
        aq.push_back(req_t'{4'h1, 8'h11}); bq.push_back(req_t'{4'h2, 8'h22});
        gq.push_back(0); gq.push_back(1);
        exp_write(4'h1, 8'h11); exp_write(4'h2, 8'h22);
        wait_idle("t2", 60);
        chk("t2_rises", rise_log.size() - base, 6);

        // T3: A saturates the FIFO with six writes.
        burst_first = 1'b1; base = rise_log.size(); stall = 0;
        aq.push_back(req_t'{4'h4, 8'h10}); aq.push_back(req_t'{4'h5, 8'h21});
        aq.push_back(req_t'{4'h6, 8'h32}); aq.push_back(req_t'{4'h7, 8'h43});
        aq.push_back(req_t'{4'h8, 8'h54}); aq.push_back(req_t'{4'h9, 8'h65});
        repeat (6) gq.push_back(0);
        exp_write(4'h4, 8'h10); exp_write(4'h5, 8'h21); exp_write(4'h6, 8'h32);
        exp_write(4'h7, 8'h43); exp_write(4'h8, 8'h54); exp_write(4'h9, 8'h65);
        wait_idle("t3", 120);
        chk("t3_stall_cycles", stall, 9);
        chk("t3_rises", rise_log.size() - base, 18);

        // T4: both continuously valid; grants alternate.
        do_reset("t4_rst");
        burst_first = 1'b1; base = rise_log.size();
        aq.push_back(req_t'{4'h1, 8'hA1}); aq.push_back(req_t'{4'h3, 8'hA3}); aq.push_back(req_t'{4'h5, 8'hA5});
        bq.push_back(req_t'{4'h2, 8'hB2}); bq.push_back(req_t'{4'h4, 8'hB4}); bq.push_back(req_t'{4'h6, 8'hB6});
        for (int i = 0; i < 6; i++) gq.push_back(i % 2);
        exp_write(4'h1, 8'hA1); exp_write(4'h2, 8'hB2); exp_write(4'h3, 8'hA3);
        exp_write(4'h4, 8'hB4); exp_write(4'h5, 8'hA5); exp_write(4'h6, 8'hB6);
        wait_idle("t4", 120);
        chk("t4_rises", rise_log.size() - base, 18);

        // T7: push lands while the FSM sits in the final DHI hold cycle.
        burst_first = 1'b1; base = rise_log.size();
        aq.push_back(req_t'{4'hD, 8'h5E}); gq.push_back(0); exp_write(4'hD, 8'h5E);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin @(negedge CLK); if (aq.size() == 0) done = 1'b1; end
        chk("t7_accept_timeout", int'(done), 1);
        acc1 = last_acc;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin @(negedge CLK); if (cyc == acc1 + 11) done = 1'b1; end
        chk("t7_sync_timeout", int'(done), 1);
        burst_first = 1'b1;
        aq.push_back(req_t'{4'h2, 8'h9C}); gq.push_back(0); exp_write(4'h2, 8'h9C);
        wait_idle("t7", 60);
        chk("t7_accept_edge", last_acc - acc1, 13);
        chk("t7_rises", rise_log.size() - base, 6);
        if (rise_log.size() >= base + 4) begin
            chk("t7_gap", rise_log[base + 3] - rise_log[base + 2], 5);
            chk("t7_latency", rise_log[base + 3] - last_acc, 2);
        end

        // T5: reset during the DLO strobe.
        burst_first = 1'b1; base = rise_log.size();
        aq.push_back(req_t'{4'hE, 8'h7C}); gq.push_back(0); exp_write(4'hE, 8'h7C);
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin @(negedge CLK); #1; if (rise_log.size() >= base + 2) done = 1'b1; end
        chk("t5_dlo_timeout", int'(done), 1);
        chk("t5_wr_before", BUS_WR, 1);
        #1 RST = 1'b0;
        #1;
        chk("t5_wr_async", BUS_WR, 0);
        chk("t5_d_async", BUS_D, 0);
        chk("t5_a0_async", BUS_A0, 0);
        chk("t5_busy_async", BUSY, 0);
        exq.delete();
        @(posedge CLK); @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        chk("t5_empty_after", BUSY, 0);
        burst_first = 1'b1; base = rise_log.size();
        aq.push_back(req_t'{4'h9, 8'h3F}); gq.push_back(0); exp_write(4'h9, 8'h3F);
        wait_idle("t5", 60);
        chk("t5_rises", rise_log.size() - base, 3);
        if (rise_log.size() > base) chk("t5_latency", rise_log[base] - last_acc, 2);

        // T6: SETUP=2, STROBE=1, HOLD=3 instance, checked cycle by cycle.
        @(posedge CLK);
        #1 RST2 = 1'b1;
        A2_VALID = 1'b1; A2_ADDR = 4'h5; A2_DATA = 8'hC3;
        @(negedge CLK);
        chk("t6_a_ready", A2_READY, 1);
        chk("t6_b_ready", B2_READY, 0);
        @(posedge CLK);
        #1 A2_VALID = 1'b0;
        chk("t6_busy_start", BUSY2, 1);
        for (int i = 0; i < 18; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            nibv = i / 6;
            ed = (nibv == 0) ? 4'h5 : (nibv == 1) ? 4'h3 : 4'hC;
            chk($sformatf("t6_wr_%0d", i), BUS2_WR, int'((i % 6) == 2));
            chk($sformatf("t6_a0_%0d", i), BUS2_A0, int'(nibv == 0));
            chk($sformatf("t6_d_%0d", i), BUS2_D, ed);
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_busy_end", BUSY2, 0);
        chk("t6_idle_d", BUS2_D, 4'hC);
        chk("t6_idle_wr", BUS2_WR, 0);

        chk("exq_drained", exq.size(), 0);
        chk("grants_drained", gq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
